// File: rtl/fetch_unit.sv
// Instruction-fetch stage with PC, IF/ID register and HLT detection.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] NOP_WORD   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted,
    output logic [15:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt,
    output logic [15:0] perf_bubble_cnt
);

    localparam int unsigned W = 16;

    typedef enum logic {
        S_RUN,
        S_HALT
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [W-1:0]   instr_q, instr_d;
    logic [W-1:0]   pc2_q, pc2_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   pc_plus2;
    logic           flush_c;
    logic           bubble_c;

    assign pc_plus2 = pc_q + W'(2);

    // Next-state: stall > redirect > memory busy > normal fetch
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc2_d    = pc2_q;
        valid_d  = valid_q;
        flush_c  = 1'b0;
        bubble_c = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (stall) begin
                    // hold everything; a pending branch waits for its operand
                end else if (branch_taken) begin
                    flush_c = 1'b1;
                    pc_d    = branch_target;
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (!imem_valid) begin
                    bubble_c = 1'b1;
                    instr_d  = NOP_WORD;
                    valid_d  = 1'b0;
                end else begin
                    instr_d = imem_data;
                    pc2_d   = pc_plus2;
                    valid_d = 1'b1;
                    if (imem_data[15:12] == HLT_OPCODE) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d = pc_plus2;
                    end
                end
            end
            S_HALT: begin
                if (!stall) begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                    if (branch_taken) begin
                        pc_d    = branch_target;
                        state_d = S_RUN;
                    end
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pc2_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc2_q   <= pc2_d;
            valid_q <= valid_d;
        end
    end

    assign imem_addr     = pc_q;
    assign ifid_instr    = instr_q;
    assign ifid_pc_plus2 = pc2_q;
    assign ifid_valid    = valid_q;
    assign halted        = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [W-1:0] stall_cnt_q, flush_cnt_q, bubble_cnt_q;

    // Saturating event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != {W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + W'(1);
            if (flush_c && (flush_cnt_q != {W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + W'(1);
            if (bubble_c && (bubble_cnt_q != {W{1'b1}}))
                bubble_cnt_q <= bubble_cnt_q + W'(1);
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_flush_cnt  = flush_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`else
    logic unused_c;
    assign unused_c        = flush_c ^ bubble_c;
    assign perf_stall_cnt  = '0;
    assign perf_flush_cnt  = '0;
    assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: fetch, stall, redirect, halt, bubbles, wrap, reset.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        imem_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
    logic [15:0] perf_bubble_cnt;

    logic [15:0] mem [0:32767];
    int n_assert = 0;
    int n_fail   = 0;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .imem_valid     (imem_valid),
        .ifid_instr     (ifid_instr),
        .ifid_pc_plus2  (ifid_pc_plus2),
        .ifid_valid     (ifid_valid),
        .halted         (halted),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_bubble_cnt(perf_bubble_cnt)
    );

    assign imem_data = mem[imem_addr[15:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] instr,
                            input logic [15:0] pc2, input logic vld);
        chk({tag, "_instr"}, ifid_instr, instr);
        chk({tag, "_pc2"}, ifid_pc_plus2, pc2);
        chk({tag, "_valid"}, 16'(ifid_valid), 16'(vld));
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'h1000 + 16'(i & 12'hFFF);
        mem[0] = 16'h1123;
        mem[1] = 16'h2456;
        mem[8] = 16'hF000;

        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        branch_target = 16'h0000; imem_valid = 1'b1;
        #12;
        chk("rst_addr", imem_addr, 16'h0000);
        chk_ifid("rst", 16'h0000, 16'h0000, 1'b0);
        chk("rst_halted", 16'(halted), 16'h0000);
        chk("rst_pstall", perf_stall_cnt, 16'h0000);
        @(negedge clk) rst_n = 1'b1;

        // Sequential fetch
        tick();
        chk_ifid("f0", 16'h1123, 16'h0002, 1'b1);
        tick();
        chk_ifid("f1", 16'h2456, 16'h0004, 1'b1);
        chk("f1_addr", imem_addr, 16'h0004);
        tick();
        chk_ifid("f2", 16'h1002, 16'h0006, 1'b1);

        // 3-cycle stall at PC 6
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_ifid("stl", 16'h1002, 16'h0006, 1'b1);
            chk("stl_addr", imem_addr, 16'h0006);
        end
        stall = 1'b0;
        chk("pstall3", perf_stall_cnt, PERF ? 16'd3 : 16'd0);
        tick();
        chk_ifid("rsm", 16'h1003, 16'h0008, 1'b1);
        chk("rsm_addr", imem_addr, 16'h0008);
        tick();
        chk("pre_br_addr", imem_addr, 16'h000A);

        // Taken branch at PC 0x0A -> 0x40
        branch_taken = 1'b1; branch_target = 16'h0040;
        tick();
        branch_taken = 1'b0;
        chk("br_valid", 16'(ifid_valid), 16'h0000);
        chk("br_addr", imem_addr, 16'h0040);
        chk("pflush1", perf_flush_cnt, PERF ? 16'd1 : 16'd0);
        tick();
        chk_ifid("tgt", 16'h1020, 16'h0042, 1'b1);

        // Stall and branch together: no redirect, no flush
        stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0010;
        tick();
        chk("sb_addr", imem_addr, 16'h0042);
        chk_ifid("sb", 16'h1020, 16'h0042, 1'b1);
        chk("sb_pflush", perf_flush_cnt, PERF ? 16'd1 : 16'd0);
        stall = 1'b0;
        tick();
        branch_taken = 1'b0;
        chk("sb2_addr", imem_addr, 16'h0010);
        chk("sb2_valid", 16'(ifid_valid), 16'h0000);

        // HLT at 0x10
        tick();
        chk_ifid("hlt", 16'hF000, 16'h0012, 1'b1);
        chk("hlt_halted", 16'(halted), 16'h0001);
        chk("hlt_addr", imem_addr, 16'h0010);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hf_addr", imem_addr, 16'h0010);
            chk("hf_valid", 16'(ifid_valid), 16'h0000);
            chk("hf_halted", 16'(halted), 16'h0001);
        end
        chk("pstall4", perf_stall_cnt, PERF ? 16'd4 : 16'd0);

        // Asynchronous reset while halted
        #2 rst_n = 1'b0;
        #1;
        chk("ar_addr", imem_addr, 16'h0000);
        chk("ar_halted", 16'(halted), 16'h0000);
        chk("ar_pstall", perf_stall_cnt, 16'h0000);
        @(negedge clk) rst_n = 1'b1;

        // Redirect near top of memory, then two bubbles and wrap
        branch_taken = 1'b1; branch_target = 16'hFFFC;
        tick();
        branch_taken = 1'b0;
        chk("w_addr", imem_addr, 16'hFFFC);
        imem_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("bub_valid", 16'(ifid_valid), 16'h0000);
            chk("bub_addr", imem_addr, 16'hFFFC);
        end
        chk("pbubble2", perf_bubble_cnt, PERF ? 16'd2 : 16'd0);
        imem_valid = 1'b1;
        tick();
        chk_ifid("fc", 16'h1FFE, 16'hFFFE, 1'b1);
        chk("fc_addr", imem_addr, 16'hFFFE);
        tick();
        chk_ifid("fe", 16'h1FFF, 16'h0000, 1'b1);
        chk("wrap_addr", imem_addr, 16'h0000);

        // Asynchronous reset mid-stall
        tick();
        stall = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ms_addr", imem_addr, 16'h0000);
        chk("ms_valid", 16'(ifid_valid), 16'h0000);
        stall = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk_ifid("post", 16'h1123, 16'h0002, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined core. Holds the PC, addresses instruction memory, and captures fetched words into IF/ID. Sits directly upstream of decode and consumes the hazard unit's `stall` together with the decode-stage branch redirect. Detects HLT in fetch and freezes the PC so no instruction past the halt enters the pipe.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP_WORD`, 16'h0000, instruction word written into IF/ID on a flush or bubble.
- `HLT_OPCODE`, 4'hF, opcode value (instr[15:12]) recognised as halt.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold request from hazard detection; freezes the PC and IF/ID.
- `branch_taken` in 1: decode-stage resolved taken branch or jump.
- `branch_target` in 16: redirect address, valid with `branch_taken`.
- `imem_addr` out 16: equals the PC register.
- `imem_data` in 16: instruction word for `imem_addr`, combinational read.
- `imem_valid` in 1: `imem_data` is valid this cycle. 0 means the memory is busy.
- `ifid_instr` out 16: IF/ID instruction.
- `ifid_pc_plus2` out 16: IF/ID PC+2 of that instruction.
- `ifid_valid` out 1: IF/ID holds a real instruction.
- `halted` out 1: fetch FSM is in HALT.
- `perf_stall_cnt`, `perf_flush_cnt`, `perf_bubble_cnt` out 16 each: performance counters (see Configuration).

## Operation
- FSM states: RUN, HALT. Reset enters RUN.
- Per-cycle priority in RUN, highest first:
  1. `stall`=1: PC and IF/ID hold. `branch_taken` is ignored, because the branch in decode is itself waiting on an operand.
  2. `branch_taken`=1: PC <= `branch_target`. IF/ID <= {`NOP_WORD`, valid 0}. The word fetched this cycle is discarded, whatever `imem_valid` is.
  3. `imem_valid`=0: PC holds. IF/ID <= {`NOP_WORD`, valid 0} (bubble).
  4. Normal fetch: IF/ID <= {`imem_data`, PC+2, valid 1}.
     - If `imem_data[15:12]`==`HLT_OPCODE`: PC holds and the FSM goes to HALT.
     - Otherwise PC <= PC+2.
- HALT state:
  - PC is frozen.
  - If `stall`=1, IF/ID holds.
  - Otherwise IF/ID <= {`NOP_WORD`, valid 0}.
  - `branch_taken`=1 with `stall`=0 is a defensive case: PC <= `branch_target`, IF/ID is flushed, and the FSM returns to RUN.
  - HALT is left only by reset or that redirect.
- Arithmetic: PC+2 is computed modulo 2^16. 16'hFFFE+2 wraps to 16'h0000 with no flag.
- Reset (asynchronous, any cycle including mid-stall or in HALT):
  - PC = `RESET_PC`; FSM = RUN.
  - `ifid_instr` = `NOP_WORD`, `ifid_pc_plus2` = 16'h0000, `ifid_valid` = 0, `halted` = 0.
  - All counters = 0.

## Timing
- `imem_addr` is valid from the register output at the start of each cycle.
- `imem_data` and `imem_valid` are sampled at the same cycle's rising edge. Fetch latency is 1 cycle from PC to IF/ID.
- Taken-branch penalty: exactly 1 bubble. The first target instruction appears in IF/ID 2 edges after the cycle in which `branch_taken` was sampled.
- A `stall` of N cycles holds IF/ID for exactly N edges. No instruction is lost or duplicated.
- `halted` rises on the same edge that loads HLT into IF/ID.
- No combinational path from `stall`/`branch_taken` to `imem_addr`.

## Configuration
- Macro: `FETCH_PERF_CNT_EN`.
- Defined: three 16-bit saturating counters (stick at 16'hFFFF), each advancing once per qualifying edge:
  - `perf_stall_cnt`: +1 per edge with `stall`=1.
  - `perf_flush_cnt`: +1 per edge taking priority 2.
  - `perf_bubble_cnt`: +1 per edge taking priority 3.
- Undefined: the counter ports remain and are tied to 16'h0000. No counter flops are synthesised.

## Test plan
- Reset, `imem_valid`=1, memory returns 16'h1123, 16'h2456:
  - After 2 edges, IF/ID = {16'h2456, pc_plus2 16'h0004, valid 1}.
  - `imem_addr`=16'h0004.
- 3-cycle `stall` at PC 16'h0006:
  - IF/ID and `imem_addr` are unchanged for 3 edges, then resume at 16'h0008.
  - With the macro defined, `perf_stall_cnt`=3.
- `branch_taken`=1, `branch_target`=16'h0040 at PC 16'h000A:
  - Next edge: `ifid_valid`=0 and `imem_addr`=16'h0040.
  - Following edge: IF/ID holds mem[16'h0040] with pc_plus2 16'h0042.
- `stall`=1 and `branch_taken`=1 in the same cycle:
  - PC is unchanged and there is no flush.
  - Next cycle, `stall`=0 with `branch_taken`=1 redirects.
- Fetch 16'hF000 at PC 16'h0010:
  - `halted`=1, `imem_addr` stays 16'h0010 indefinitely, and all later IF/ID entries have `ifid_valid`=0.
- `imem_valid`=0 for 2 cycles mid-run, then PC 16'hFFFE fetched:
  - Two bubbles are inserted.
  - After the fetch, `imem_addr` wraps to 16'h0000.
  - Asserting `rst_n`=0 mid-sequence immediately gives PC 16'h0000 and `ifid_valid`=0.
